if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction-fetch stage. It sits directly downstream of the PC register and upstream of the IF/ID latch.
- Accepts a word-aligned fetch address plus request from the PC register and returns a 32-bit instruction to IF/ID.
- Misses are filled byte-by-byte over the memory controller's 8-bit RAM port (4 reads, 1-cycle RAM latency, little-endian assembly).
- A small direct-mapped instruction cache sits in front of the RAM port. Its `busy_o` output drives the PC register's `mem_busy` input, so the PC holds while a fetch is outstanding.

Parameters:
- ICACHE_LINES, 64, number of one-word direct-mapped lines (power of 2, ≥2).
- INDEX_W, log2(ICACHE_LINES), index width; tag width = 30 - INDEX_W.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset (`RstEnable` = 1).
- pc_i  in  32  fetch address from the PC register; bits [1:0] ignored.
- pc_memreq_i  in  1  fetch request from the PC register.
- flush_i  in  1  PC redirect (set_pc); aborts the current fetch.
- stall_i  in  6  pipeline stall vector; bit 1 = IF/ID stalled.
- mem_req_o  out  1  byte read request to the memory controller.
- mem_addr_o  out  32  byte address of the read.
- mem_grant_i  in  1  memory controller accepts the request this cycle.
- mem_data_i  in  8  read byte, valid the cycle after a granted request.
- busy_o  out  1  to the PC register's `mem_busy`.
- inst_o  out  32  fetched instruction.
- inst_pc_o  out  32  address of `inst_o`.
- inst_valid_o  out  1  `inst_o`/`inst_pc_o` valid.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; all cache valid bits cleared.
  - inst_o=0, inst_pc_o=0, inst_valid_o=0, mem_req_o=0, mem_addr_o=0.
  - Any pending byte is discarded. Reset mid-fetch aborts the fetch with no cache write.
- busy_o (combinational) = !flush_i && (state!=IDLE || (inst_valid_o && stall_i[1])).
- Accept condition: pc_memreq_i && !busy_o && !flush_i in IDLE. At the accepting edge, latch pc_q={pc_i[31:2],2'b00}.
- Hit (valid[idx] && tag match, idx=pc_i[INDEX_W+1:2]):
  - At the next edge inst_o=line data, inst_pc_o=pc_q, inst_valid_o=1.
  - State stays IDLE, giving 1 instruction/cycle throughput.
- Miss: go to B0. Sequence is B0 → B1 → B2 → B3 → LAST → IDLE.
  - In Bk: mem_req_o=1, mem_addr_o=pc_q+k.
  - State advances only at an edge where mem_grant_i=1; otherwise it holds with the same address.
  - A granted issue sets byte_pend with index k. The next cycle captures mem_data_i into byte lane k (bits 8k+7:8k).
  - LAST: mem_req_o=0, capture byte 3, then:
    - write {tag,word} into the cache and set the valid bit;
    - drive inst_o/inst_pc_o with inst_valid_o=1 at the same edge;
    - return to IDLE.
  - Latency with continuous grant: inst_valid_o rises at the 5th edge after the accepting edge.
- Output hold:
  - inst_valid_o clears at the next edge unless stall_i[1]=1, in which case outputs hold unchanged.
  - busy_o stays high while held, so no new accept occurs.
- flush_i:
  - At the edge: state→IDLE, inst_valid_o→0, byte_pend→0, no cache write, no accept that cycle.
  - busy_o is forced 0 so the PC register can load the redirect target.
  - A byte returning after the flush is ignored.
  - Flush wins over fill completion, hit and stall hold.
- Simultaneous rst and flush_i: reset wins.
- Address arithmetic: pc_q+k uses 32-bit wrap-around; bits [1:0] never carry.

Decomposition:
- Shared defines: `RstEnable`, `InstAddrBus` (31:0), `InstBus` (31:0), `ByteBus` (7:0), state encodings IF_IDLE/IF_B0..IF_B3/IF_LAST.
- Sub-module `icache_dm`: tag/data/valid arrays.
  - Combinational lookup: hit + data.
  - Synchronous write port, plus valid clear on rst.

Test Plan:
- Miss, full grant: RAM[0..3]=13,05,10,00; accept pc=0 → mem_addr_o 0,1,2,3 on consecutive cycles; inst_o=0x00100513, inst_pc_o=0, inst_valid_o=1 at the 5th edge; busy_o low afterwards.
- Hit: re-request pc=0 → inst_valid_o at the 1st edge, mem_req_o never asserted; back-to-back hits at pc=0 and pc=4 give one instruction per cycle.
- Grant gaps: mem_grant_i low for 2 cycles during B2 → mem_addr_o holds 0x2 and the result is delayed by exactly 2 cycles with the correct word.
- Flush: flush_i pulse during B1 of fetch pc=0x10 → busy_o=0 that cycle, no inst_valid_o, cache line for 0x10 still invalid, next request pc=0x40 fetched correctly.
- Stall: stall_i[1]=1 for 3 cycles at completion → inst_o/inst_pc_o/inst_valid_o held, busy_o=1, pc_memreq_i ignored; released → valid drops next edge.
- Reset mid-fill: rst in B3 → all outputs 0, state IDLE; re-fetch of the same pc misses (4 RAM reads).

Source files
------------

// File: rtl/if_fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : if_fetch_pkg                                                |
// | Brief  : Shared types, reset polarity and fetch-FSM state encodings. |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package if_fetch_pkg;

    localparam logic RstEnable = 1'b1;

    typedef logic [31:0] inst_addr_t;
    typedef logic [31:0] inst_t;
    typedef logic [7:0]  byte_t;

    typedef enum logic [2:0] {
        IF_IDLE = 3'd0,
        IF_B0   = 3'd1,
        IF_B1   = 3'd2,
        IF_B2   = 3'd3,
        IF_B3   = 3'd4,
        IF_LAST = 3'd5
    } if_state_e;

    // Byte lane (and low address bits) fetched while in a byte-issue state.
    function automatic logic [1:0] byte_lane(input if_state_e s);
        case (s)
            IF_B1:   return 2'd1;
            IF_B2:   return 2'd2;
            IF_B3:   return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_fetch_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : if_fetch_if                                                 |
// | Brief  : PC-side, pipeline-side and RAM-port signals of fetch stage. |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
interface if_fetch_if;
    import if_fetch_pkg::*;

    inst_addr_t  pc_i;
    logic        pc_memreq_i;
    logic        flush_i;
    logic [5:0]  stall_i;
    logic        mem_req_o;
    inst_addr_t  mem_addr_o;
    logic        mem_grant_i;
    byte_t       mem_data_i;
    logic        busy_o;
    inst_t       inst_o;
    inst_addr_t  inst_pc_o;
    logic        inst_valid_o;

    modport slave (
        input  pc_i, pc_memreq_i, flush_i, stall_i, mem_grant_i, mem_data_i,
        output mem_req_o, mem_addr_o, busy_o, inst_o, inst_pc_o, inst_valid_o
    );

    modport master (
        output pc_i, pc_memreq_i, flush_i, stall_i, mem_grant_i, mem_data_i,
        input  mem_req_o, mem_addr_o, busy_o, inst_o, inst_pc_o, inst_valid_o
    );
endinterface
`default_nettype wire

// File: rtl/if_fetch_icache_dm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : icache_dm                                                   |
// | Brief  : Direct-mapped one-word-per-line instruction cache arrays.   |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module icache_dm
    import if_fetch_pkg::*;
#(
    parameter int LINES   = 64,
    parameter int INDEX_W = $clog2(LINES)
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic [INDEX_W-1:0]    rd_idx,
    input  wire logic [29-INDEX_W:0]   rd_tag,
    output      logic                  rd_hit,
    output      inst_t                 rd_data,
    input  wire logic                  we,
    input  wire logic [INDEX_W-1:0]    wr_idx,
    input  wire logic [29-INDEX_W:0]   wr_tag,
    input  wire inst_t                 wr_data
);
    localparam int c_tag_w = 30 - INDEX_W;

    logic [LINES-1:0]   r_valid;
    logic [c_tag_w-1:0] r_tag  [LINES];
    inst_t              r_data [LINES];

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_valid <= '0;
        end else if (we) begin
            r_valid[wr_idx] <= 1'b1;
        end
    end

    // Tag/data need no reset: a line is only consulted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (we) begin
            r_tag[wr_idx]  <= wr_tag;
            r_data[wr_idx] <= wr_data;
        end
    end

    assign rd_hit  = r_valid[rd_idx] && (r_tag[rd_idx] == rd_tag);
    assign rd_data = r_data[rd_idx];

endmodule
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : if_fetch                                                    |
// | Brief  : Instruction fetch with DM I-cache and byte-wide miss fill.  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int ICACHE_LINES = 64,
    parameter int INDEX_W      = $clog2(ICACHE_LINES)
) (
    input  wire logic  clk,
    input  wire logic  rst,
    if_fetch_if.slave  bus
);
    if_state_e   r_state;
    if_state_e   w_next_state;
    inst_addr_t  r_pc_q;
    inst_t       r_word;
    inst_t       r_inst;
    inst_addr_t  r_inst_pc;
    logic        r_inst_valid;
    logic        r_byte_pend;
    logic [1:0]  r_byte_lane;

    logic        w_busy;
    logic        w_accept;
    logic        w_hit;
    inst_t       w_rd_data;
    logic        w_cache_we;
    logic        w_mem_req;
    inst_addr_t  w_mem_addr;
    logic [1:0]  w_lane;
    logic        w_granted;
    inst_t       w_fill_word;
    logic        w_unused_bits;

    icache_dm #(
        .LINES   (ICACHE_LINES),
        .INDEX_W (INDEX_W)
    ) u_icache (
        .clk     (clk),
        .rst     (rst),
        .rd_idx  (bus.pc_i[INDEX_W+1:2]),
        .rd_tag  (bus.pc_i[31:INDEX_W+2]),
        .rd_hit  (w_hit),
        .rd_data (w_rd_data),
        .we      (w_cache_we),
        .wr_idx  (r_pc_q[INDEX_W+1:2]),
        .wr_tag  (r_pc_q[31:INDEX_W+2]),
        .wr_data (w_fill_word)
    );

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_state <= IF_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_mem_req    = 1'b0;
        w_mem_addr   = '0;
        w_lane       = 2'd0;
        w_cache_we   = 1'b0;
        w_accept     = 1'b0;
        w_busy       = !bus.flush_i &&
                       ((r_state != IF_IDLE) || (r_inst_valid && bus.stall_i[1]));

        case (r_state)
            IF_IDLE: begin
                if (bus.pc_memreq_i && !w_busy && !bus.flush_i) begin
                    w_accept = 1'b1;
                    if (!w_hit) begin
                        w_next_state = IF_B0;
                    end
                end
            end
            IF_B0, IF_B1, IF_B2, IF_B3: begin
                w_mem_req  = 1'b1;
                w_lane     = byte_lane(r_state);
                w_mem_addr = {r_pc_q[31:2], w_lane};
                if (bus.mem_grant_i) begin
                    case (r_state)
                        IF_B0:   w_next_state = IF_B1;
                        IF_B1:   w_next_state = IF_B2;
                        IF_B2:   w_next_state = IF_B3;
                        default: w_next_state = IF_LAST;
                    endcase
                end
            end
            IF_LAST: begin
                w_cache_we   = 1'b1;
                w_next_state = IF_IDLE;
            end
            default: w_next_state = IF_IDLE;
        endcase

        // A redirect overrides fill completion, hits and new accepts.
        if (bus.flush_i) begin
            w_next_state = IF_IDLE;
            w_accept     = 1'b0;
            w_cache_we   = 1'b0;
        end
    end

    assign w_granted   = w_mem_req && bus.mem_grant_i;
    assign w_fill_word = {bus.mem_data_i, r_word[23:0]};

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_pc_q       <= '0;
            r_word       <= '0;
            r_inst       <= '0;
            r_inst_pc    <= '0;
            r_inst_valid <= 1'b0;
            r_byte_pend  <= 1'b0;
            r_byte_lane  <= 2'd0;
        end else if (bus.flush_i) begin
            r_inst_valid <= 1'b0;
            r_byte_pend  <= 1'b0;
        end else begin
            r_byte_pend <= w_granted;
            r_byte_lane <= w_lane;
            if (r_byte_pend) begin
                r_word[{r_byte_lane, 3'b000} +: 8] <= bus.mem_data_i;
            end
            if (w_accept) begin
                r_pc_q <= {bus.pc_i[31:2], 2'b00};
            end
            if (w_accept && w_hit) begin
                r_inst       <= w_rd_data;
                r_inst_pc    <= {bus.pc_i[31:2], 2'b00};
                r_inst_valid <= 1'b1;
            end else if (w_cache_we) begin
                r_inst       <= w_fill_word;
                r_inst_pc    <= r_pc_q;
                r_inst_valid <= 1'b1;
            end else if (!(r_inst_valid && bus.stall_i[1])) begin
                r_inst_valid <= 1'b0;
            end
        end
    end

    assign bus.mem_req_o    = w_mem_req;
    assign bus.mem_addr_o   = w_mem_addr;
    assign bus.busy_o       = w_busy;
    assign bus.inst_o       = r_inst;
    assign bus.inst_pc_o    = r_inst_pc;
    assign bus.inst_valid_o = r_inst_valid;

    assign w_unused_bits = ^{bus.pc_i[1:0], bus.stall_i[5:2], bus.stall_i[0]};

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_if_fetch                                                 |
// | Brief  : Self-checking bench for if_fetch with byte-RAM model.       |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_if_fetch;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } exp_t;

    typedef struct {
        logic [31:0] pc;
        int          reads;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        grant_en = 1'b1;
    logic [7:0]  ram [1024];
    int          reads = 0;
    logic [31:0] addr_log [$];
    exp_t        sb [$];
    int          checks = 0;
    int          errors = 0;
    logic        last_valid = 1'b0;
    logic        last_stall = 1'b0;

    always #5 clk = ~clk;

    if_fetch_if bus ();

    if_fetch #(.ICACHE_LINES(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    assign bus.mem_grant_i = bus.mem_req_o & grant_en;

    // Byte RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (bus.mem_req_o && bus.mem_grant_i) begin
            bus.mem_data_i <= ram[bus.mem_addr_o[9:0]];
            reads          <= reads + 1;
            addr_log.push_back(bus.mem_addr_o);
        end else begin
            bus.mem_data_i <= 8'hA5;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] pc);
        logic [9:0] a;
        a = {pc[9:2], 2'b00};
        return {ram[a + 10'd3], ram[a + 10'd2], ram[a + 10'd1], ram[a]};
    endfunction

    // Scoreboard: each newly presented instruction pops one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.inst_valid_o && !(last_valid && last_stall)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_inst: got pc %h inst %h expected none",
                         bus.inst_pc_o, bus.inst_o);
            end else begin
                e = sb.pop_front();
                chk("sb_inst", bus.inst_o, e.inst);
                chk("sb_pc", bus.inst_pc_o, e.pc);
            end
        end
        last_valid <= bus.inst_valid_o;
        last_stall <= bus.stall_i[1];
    end

    task automatic wait_idle();
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (!bus.busy_o) return;
        end
        chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_fetch(input logic [31:0] pc, input int exp_reads, input int exp_lat,
                            input int gap_byte, input int gap_len);
        int r0;
        int lat;
        int gaps;
        logic [31:0] base;
        base = {pc[31:2], 2'b00};
        wait_idle();
        @(posedge clk);
        #1;
        bus.pc_i        = pc;
        bus.pc_memreq_i = 1'b1;
        r0              = reads;
        addr_log.delete();
        sb.push_back({model(pc), base});
        lat  = 0;
        gaps = 0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) bus.pc_memreq_i = 1'b0;
            @(negedge clk);
            if (bus.inst_valid_o) begin
                lat = c;
                break;
            end
            if (bus.mem_req_o && bus.mem_addr_o[1:0] == 2'(gap_byte) && gaps < gap_len) begin
                grant_en = 1'b0;
                gaps++;
                chk("gap_addr_hold", bus.mem_addr_o, base + 32'(gap_byte));
            end else begin
                grant_en = 1'b1;
            end
        end
        grant_en = 1'b1;
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("ram_reads", 32'(reads - r0), 32'(exp_reads));
        if (exp_reads == 4 && addr_log.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("addr_seq", addr_log[i], base + 32'(i));
        end
    endtask

    vec_t tbl [11];

    initial begin
        int found;
        int bad;

        tbl[0]  = '{32'h0000_0000, 0, 1};
        tbl[1]  = '{32'h0000_0004, 4, 6};
        tbl[2]  = '{32'h0000_0004, 0, 1};
        tbl[3]  = '{32'h0000_0104, 4, 6};
        tbl[4]  = '{32'h0000_0004, 4, 6};
        tbl[5]  = '{32'h0000_0104, 4, 6};
        tbl[6]  = '{32'h0000_0004, 4, 6};
        tbl[7]  = '{32'h0000_0003, 0, 1};
        tbl[8]  = '{32'hFFFF_FFFC, 4, 6};
        tbl[9]  = '{32'hFFFF_FFFC, 0, 1};
        tbl[10] = '{32'h0000_03FC, 4, 6};

        for (int i = 0; i < 1024; i++) ram[i] = 8'(i * 37 + 11);
        ram[0] = 8'h13; ram[1] = 8'h05; ram[2] = 8'h10; ram[3] = 8'h00;

        bus.pc_i        = '0;
        bus.pc_memreq_i = 1'b0;
        bus.flush_i     = 1'b0;
        bus.stall_i     = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_inst", bus.inst_o, 32'h0);
        chk("rst_inst_pc", bus.inst_pc_o, 32'h0);
        chk("rst_valid", 32'(bus.inst_valid_o), 32'h0);
        chk("rst_mem_req", 32'(bus.mem_req_o), 32'h0);
        chk("rst_mem_addr", bus.mem_addr_o, 32'h0);
        chk("rst_busy", 32'(bus.busy_o), 32'h0);

        // First miss with continuous grant.
        do_fetch(32'h0, 4, 6, 0, 0);
        chk("miss0_inst", bus.inst_o, 32'h0010_0513);
        @(negedge clk);
        chk("miss0_busy_after", 32'(bus.busy_o), 32'h0);
        chk("miss0_valid_drop", 32'(bus.inst_valid_o), 32'h0);

        for (int i = 0; i < 11; i++) do_fetch(tbl[i].pc, tbl[i].reads, tbl[i].lat, 0, 0);

        // Back-to-back hits at 0 and 4.
        wait_idle();
        found = reads;
        @(posedge clk);
        #1;
        bus.pc_i = 32'h0; bus.pc_memreq_i = 1'b1;
        sb.push_back({model(32'h0), 32'h0});
        @(posedge clk);
        #1;
        bus.pc_i = 32'h4;
        sb.push_back({model(32'h4), 32'h4});
        @(negedge clk);
        chk("b2b_valid0", 32'(bus.inst_valid_o), 32'h1);
        @(posedge clk);
        #1 bus.pc_memreq_i = 1'b0;
        @(negedge clk);
        chk("b2b_valid1", 32'(bus.inst_valid_o), 32'h1);
        chk("b2b_pc1", bus.inst_pc_o, 32'h4);
        chk("b2b_no_reads", 32'(reads - found), 32'h0);

        // Grant withheld for two cycles in B2.
        do_fetch(32'h8, 4, 8, 2, 2);

        // Redirect during B1 of a miss at 0x10.
        wait_idle();
        @(posedge clk);
        #1;
        bus.pc_i = 32'h10; bus.pc_memreq_i = 1'b1;
        found = 0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) bus.pc_memreq_i = 1'b0;
            @(negedge clk);
            if (bus.mem_req_o && bus.mem_addr_o == 32'h11) begin
                bus.flush_i = 1'b1;
                #1 chk("flush_busy", 32'(bus.busy_o), 32'h0);
                found = 1;
                break;
            end
        end
        chk("flush_reached_b1", 32'(found), 32'h1);
        @(posedge clk);
        #1 bus.flush_i = 1'b0;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.inst_valid_o) bad++;
        end
        chk("flush_no_valid", 32'(bad), 32'h0);
        chk("flush_idle", 32'(bus.busy_o), 32'h0);
        do_fetch(32'h40, 4, 6, 0, 0);
        do_fetch(32'h10, 4, 6, 0, 0);

        // IF/ID stall held across completion of a miss at 0x20.
        wait_idle();
        @(posedge clk);
        #1;
        bus.stall_i = 6'b000010;
        bus.pc_i = 32'h20; bus.pc_memreq_i = 1'b1;
        sb.push_back({model(32'h20), 32'h20});
        found = 0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) bus.pc_memreq_i = 1'b0;
            @(negedge clk);
            if (bus.inst_valid_o) begin
                found = c;
                break;
            end
        end
        chk("stall_fill_lat", 32'(found), 32'd6);
        bus.pc_i = 32'h0; bus.pc_memreq_i = 1'b1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("stall_hold_valid", 32'(bus.inst_valid_o), 32'h1);
            chk("stall_hold_inst", bus.inst_o, model(32'h20));
            chk("stall_hold_pc", bus.inst_pc_o, 32'h20);
            chk("stall_busy", 32'(bus.busy_o), 32'h1);
        end
        bus.stall_i = '0;
        bus.pc_memreq_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("stall_release_valid", 32'(bus.inst_valid_o), 32'h0);
        chk("stall_release_busy", 32'(bus.busy_o), 32'h0);

        // Reset while in B3 of a miss at 0x30.
        wait_idle();
        @(posedge clk);
        #1;
        bus.pc_i = 32'h30; bus.pc_memreq_i = 1'b1;
        found = 0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) bus.pc_memreq_i = 1'b0;
            @(negedge clk);
            if (bus.mem_req_o && bus.mem_addr_o == 32'h33) begin
                rst = 1'b1;
                found = 1;
                break;
            end
        end
        chk("rst_reached_b3", 32'(found), 32'h1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_inst", bus.inst_o, 32'h0);
        chk("midrst_inst_pc", bus.inst_pc_o, 32'h0);
        chk("midrst_valid", 32'(bus.inst_valid_o), 32'h0);
        chk("midrst_mem_req", 32'(bus.mem_req_o), 32'h0);
        chk("midrst_mem_addr", bus.mem_addr_o, 32'h0);
        chk("midrst_busy", 32'(bus.busy_o), 32'h0);
        do_fetch(32'h30, 4, 6, 0, 0);
        do_fetch(32'h0, 4, 6, 0, 0);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
